sap_cpu_core: RTL and testbench
===============================

# sap_cpu_core

Parametrised accumulator CPU core: the next generation of the 8-bit SAP datapath and control sequencer, with configurable data/address width and register-file depth. It adds a handshaked external memory port with wait states, a store instruction, conditional jumps and register-to-register ALU ops. It replaces the program counter, MAR, IR, accumulator, B register, ALU and output register group, and drives the memory and output ports directly instead of sharing a tristate bus.

## Interface
- DATA_W, 8, data and instruction word width (≥ 8); instruction = {opcode[3:0], operand[DATA_W-5:0]}
- ADDR_W, 4, memory address width (≤ DATA_W-4); address = operand[ADDR_W-1:0]
- NUM_REGS, 4, register-file entries including accumulator R0 = A (2..16)

- clk  in  1  single clock, rising edge
- clr  in  1  asynchronous, active-low reset
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  read request, held until accepted
- mem_wr  out  1  write request, held until accepted
- mem_wdata  out  DATA_W  write data (= A)
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  accepts the current request this cycle
- out_data  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse when out_data is updated
- acc  out  DATA_W  A, for observation
- pc  out  ADDR_W  program counter
- carry_flag, zero_flag  out  1 each  ALU flags
- halted  out  1  high in HALT

## Operation
- Reset: all outputs, PC, IR, flags and registers = 0; state = FETCH.
- States: FETCH → DECODE → (MEM) → FETCH; HLT → HALT (terminal until clr).
- FETCH: mem_addr=pc, mem_rd=1. On mem_ready: IR <= mem_rdata, pc <= pc+1 mod 2^ADDR_W.
- DECODE executes non-memory ops and returns to FETCH. Memory ops go to MEM.
- MEM: mem_addr = operand address; mem_rd or mem_wr held until mem_ready; the result is written at the accepting edge.
- Opcodes:
  - 0 NOP.
  - 1 LDA a: A<=M[a].
  - 2 ADD a: A<=A+M[a].
  - 3 SUB a: A<=A-M[a].
  - 4 STA a: M[a]<=A.
  - 5 LDI i: A<=zero-extended operand.
  - 6 JMP a.
  - 7 JC a.
  - 8 JZ a.
  - 9 MOV r: R[r]<=A.
  - A MVA r: A<=R[r].
  - B ADR r: A<=A+R[r].
  - C SBR r: A<=A-R[r].
  - D OUT: out_data<=A, out_valid=1 for one cycle.
  - E: NOP.
  - F HLT.
- Register select r = operand[3:0]. If r ≥ NUM_REGS: NOP, no flag change. MOV 0 leaves A unchanged.
- Arithmetic is DATA_W bits, modulo.
  - Add: carry = carry-out.
  - Subtract: A + ~B + 1, carry = 1 when no borrow.
- carry_flag changes only on ADD/SUB/ADR/SBR.
- zero_flag = (new A == 0) on every write to A (LDA, ADD, SUB, LDI, MVA, ADR, SBR).
- Jumps: pc <= a in DECODE if the condition holds; otherwise pc is unchanged (already incremented).
- mem_rd and mem_wr are never both high. Both are 0 outside FETCH and MEM.

## Timing
- Zero-wait memory (mem_ready=1):
  - non-memory instructions: 2 cycles;
  - LDA/ADD/SUB/STA: 3 cycles.
- Each mem_ready=0 cycle adds one cycle. mem_addr, mem_rd, mem_wr and mem_wdata are stable while waiting.
- out_valid goes high the cycle after the OUT DECODE edge and stays high exactly 1 cycle.
- halted rises the cycle after the HLT DECODE edge. In HALT, mem_rd, mem_wr and out_valid = 0 and all state is frozen.
- clr low at any time, including mid-request: outputs are 0 immediately (asynchronous). The first FETCH issues on the cycle after clr deasserts.
- PC wraps from 2^ADDR_W-1 to 0 without side effects.

## Test plan
Defaults, zero-wait memory unless stated.
- Basic program: M = {0:LDA E, 1:ADD F, 2:OUT, 3:HLT, E:0x1C, F:0x0E} → out_data=0x2A with a single out_valid pulse, carry=0, zero=0; halted rises 10 cycles after reset release.
- Carry and zero: LDI F, ADD a with M[a]=0xF1 → A=0x00, carry=1, zero=1; the following JC 9 is taken (pc=9); a JZ with zero=0 is not taken.
- Borrow: LDI 3, SUB a with M[a]=0x05 → A=0xFE, carry=0, zero=0. STA to address 0xD → mem_wr with mem_addr=0xD, mem_wdata=0xFE.
- Wait states: mem_ready low for 3 cycles during the LDA fetch and 2 during its operand read → LDA takes 8 cycles; mem_addr and mem_rd are stable throughout.
- Register file: LDI 7, MOV 2, LDI 1, ADR 2 → A=8, carry=0. MOV 5 (≥ NUM_REGS) → no state change. MVA 2 → A=7.
- Reset and wrap: clr pulsed low mid-operand-read → mem_rd drops at once and pc=0 after release. A 16-NOP memory → pc goes 15→0 and fetching continues.

Source files
------------

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: parametrised accumulator CPU with a handshaked memory port.
//
// Parameters:
//   DATA_W   - data/instruction width; instruction = {opcode[3:0], operand}
//   ADDR_W   - memory address width; address = operand[ADDR_W-1:0]
//   NUM_REGS - register-file entries, R0 is the accumulator A
//
// Ports:
//   clk        - rising-edge clock
//   clr        - asynchronous active-low reset
//   mem_addr   - memory address (pc in FETCH, operand address in MEM)
//   mem_rd     - read request, held until mem_ready
//   mem_wr     - write request, held until mem_ready
//   mem_wdata  - write data (A)
//   mem_rdata  - read data, valid with mem_ready
//   mem_ready  - memory accepts the current request this cycle
//   out_data   - output register, loaded by OUT
//   out_valid  - one-cycle pulse after out_data is loaded
//   acc        - accumulator A
//   pc         - program counter
//   carry_flag - ALU carry (1 = no borrow on subtract)
//   zero_flag  - last value written to A was zero
//   halted     - core has executed HLT
`timescale 1ns/1ps

module sap_cpu_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              halted
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JC,
        OP_JZ, OP_MOV, OP_MVA, OP_ADR, OP_SBR, OP_OUT, OP_RSVD, OP_HLT
    } op_e;

    state_e            state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    op_e               opcode;
    logic [ADDR_W-1:0] op_addr;
    logic [3:0]        reg_sel;
    logic [DATA_W-1:0] imm;

    assign opcode  = op_e'(ir[DATA_W-1 -: 4]);
    assign op_addr = ir[ADDR_W-1:0];
    assign reg_sel = ir[3:0];
    assign imm     = {4'b0, ir[DATA_W-5:0]};

    // Register read; R0 aliases the accumulator, out-of-range selects flag reg_ok=0.
    logic [DATA_W-1:0] reg_val;
    logic              reg_ok;

    always_comb begin
        reg_val = acc;
        reg_ok  = (reg_sel == 4'd0);
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (reg_sel == 4'(i)) begin
                reg_val = regs[i];
                reg_ok  = 1'b1;
            end
        end
    end

    // Shared adder: subtract is A + ~B + 1, so carry-out means "no borrow".
    logic              is_sub;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;

    always_comb begin
        is_sub  = (opcode == OP_SUB) || (opcode == OP_SBR);
        alu_b   = (state == S_MEM) ? mem_rdata : reg_val;
        if (is_sub) alu_b = ~alu_b;
        alu_sum = {1'b0, acc} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};
    end

    // Request strobes decode straight from state so a fetch is presented as
    // soon as clr releases; gating with clr drops them the instant clr falls.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        if (clr) begin
            if (state == S_FETCH) begin
                mem_rd   = 1'b1;
                mem_addr = pc;
            end else if (state == S_MEM) begin
                mem_addr = op_addr;
                if (opcode == OP_STA) mem_wr = 1'b1;
                else                  mem_rd = 1'b1;
            end
        end
    end

    assign mem_wdata = acc;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            acc        <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            halted     <= 1'b0;
            for (int unsigned i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 1'b1;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: state <= S_MEM;
                        OP_LDI: begin
                            acc       <= imm;
                            zero_flag <= (imm == '0);
                        end
                        OP_JMP: pc <= op_addr;
                        OP_JC:  if (carry_flag) pc <= op_addr;
                        OP_JZ:  if (zero_flag)  pc <= op_addr;
                        OP_MOV: begin
                            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                                if (reg_sel == 4'(i)) regs[i] <= acc;
                            end
                        end
                        OP_MVA: begin
                            if (reg_ok) begin
                                acc       <= reg_val;
                                zero_flag <= (reg_val == '0);
                            end
                        end
                        OP_ADR, OP_SBR: begin
                            if (reg_ok) begin
                                acc        <= alu_sum[DATA_W-1:0];
                                carry_flag <= alu_sum[DATA_W];
                                zero_flag  <= (alu_sum[DATA_W-1:0] == '0);
                            end
                        end
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                        case (opcode)
                            OP_LDA: begin
                                acc       <= mem_rdata;
                                zero_flag <= (mem_rdata == '0);
                            end
                            OP_ADD, OP_SUB: begin
                                acc        <= alu_sum[DATA_W-1:0];
                                carry_flag <= alu_sum[DATA_W];
                                zero_flag  <= (alu_sum[DATA_W-1:0] == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_cpu_core.sv
`timescale 1ns/1ps

module tb_sap_cpu_core;

    logic       clk;
    logic       clr;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] acc;
    logic [3:0] pc;
    logic       carry_flag;
    logic       zero_flag;
    logic       halted;

    logic [7:0] mem [16];
    logic       wr_seen;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .acc        (acc),
        .pc         (pc),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Accepted writes are logged rather than stored; programs never read them back.
    always @(posedge clk) begin
        if (mem_wr && mem_ready) begin
            wr_seen <= 1'b1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds clr low, clears memory, leaves the bench at a negedge with clr still low.
    task automatic do_reset();
        clr       = 1'b0;
        mem_ready = 1'b1;
        wr_seen   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 00", acc); end
        checks++; if ({out_valid, halted, carry_flag, zero_flag} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {out_valid, halted, carry_flag, zero_flag});
        end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    endtask

    task automatic test_basic();
        int halt_cyc;
        int out_cyc;
        int pulses;
        do_reset();
        mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'hD0; mem[3] = 8'hF0;
        mem[14] = 8'h1C; mem[15] = 8'h0E;
        clr = 1'b1;
        halt_cyc = -1; out_cyc = -1; pulses = 0;
        for (int c = 1; c <= 40 && halt_cyc < 0; c++) begin
            tick(1);
            if (out_valid) begin pulses++; out_cyc = c; end
            if (halted) halt_cyc = c;
        end
        checks++; if (halt_cyc != 10) begin errors++; $display("FAIL basic_halt_cycle got %0d want 10", halt_cyc); end
        checks++; if (out_data !== 8'h2A) begin errors++; $display("FAIL basic_out_data got %h want 2a", out_data); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL basic_out_pulses got %0d want 1", pulses); end
        checks++; if (out_cyc != 8) begin errors++; $display("FAIL basic_out_cycle got %0d want 8", out_cyc); end
        checks++; if ({carry_flag, zero_flag} !== 2'b00) begin
            errors++; $display("FAIL basic_flags got %b want 00", {carry_flag, zero_flag});
        end
        tick(3);
        checks++; if (pc !== 4'h4) begin errors++; $display("FAIL halt_pc_frozen got %h want 4", pc); end
        checks++; if ({mem_rd, mem_wr, out_valid, halted} !== 4'b0001) begin
            errors++; $display("FAIL halt_outputs got %b want 0001", {mem_rd, mem_wr, out_valid, halted});
        end
        checks++; if (acc !== 8'h2A) begin errors++; $display("FAIL halt_acc got %h want 2a", acc); end
    endtask

    task automatic test_carry_zero();
        do_reset();
        // LDI F; ADD C; JC 9; ... 9: LDI 1; JZ 4; HLT ; M[C]=F1
        mem[0] = 8'h5F; mem[1] = 8'h2C; mem[2] = 8'h79;
        mem[9] = 8'h51; mem[10] = 8'h84; mem[11] = 8'hF0;
        mem[12] = 8'hF1;
        clr = 1'b1;
        tick(5);
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL cz_acc got %h want 00", acc); end
        checks++; if ({carry_flag, zero_flag} !== 2'b11) begin
            errors++; $display("FAIL cz_flags got %b want 11", {carry_flag, zero_flag});
        end
        tick(2);
        checks++; if (pc !== 4'h9) begin errors++; $display("FAIL jc_taken_pc got %h want 9", pc); end
        tick(4);
        checks++; if (pc !== 4'hB) begin errors++; $display("FAIL jz_not_taken_pc got %h want b", pc); end
        checks++; if ({carry_flag, zero_flag} !== 2'b10) begin
            errors++; $display("FAIL ldi_keeps_carry got %b want 10", {carry_flag, zero_flag});
        end
        tick(2);
        checks++; if ({halted, acc} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL cz_end got halted=%b acc=%h want 1 01", halted, acc);
        end
    endtask

    task automatic test_borrow_store();
        do_reset();
        // LDI 3; SUB C; STA D; HLT ; M[C]=05
        mem[0] = 8'h53; mem[1] = 8'h3C; mem[2] = 8'h4D; mem[3] = 8'hF0;
        mem[12] = 8'h05;
        clr = 1'b1;
        tick(5);
        checks++; if (acc !== 8'hFE) begin errors++; $display("FAIL borrow_acc got %h want fe", acc); end
        checks++; if ({carry_flag, zero_flag} !== 2'b00) begin
            errors++; $display("FAIL borrow_flags got %b want 00", {carry_flag, zero_flag});
        end
        tick(2);
        checks++; if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hD, 8'hFE}) begin
            errors++; $display("FAIL sta_request got wr=%b rd=%b addr=%h data=%h want 1 0 d fe",
                               mem_wr, mem_rd, mem_addr, mem_wdata);
        end
        tick(1);
        checks++; if ({wr_seen, wr_addr, wr_data} !== {1'b1, 4'hD, 8'hFE}) begin
            errors++; $display("FAIL sta_write got seen=%b addr=%h data=%h want 1 d fe", wr_seen, wr_addr, wr_data);
        end
        checks++; if ({mem_wr, mem_rd, mem_addr} !== {1'b0, 1'b1, 4'h3}) begin
            errors++; $display("FAIL sta_done got wr=%b rd=%b addr=%h want 0 1 3", mem_wr, mem_rd, mem_addr);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        mem[0] = 8'h1E; mem[1] = 8'hF0; mem[14] = 8'h5A;
        mem_ready = 1'b0;
        clr = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 4'h0}) begin
                errors++; $display("FAIL wait_fetch_%0d got rd=%b wr=%b addr=%h want 1 0 0", i, mem_rd, mem_wr, mem_addr);
            end
            tick(1);
        end
        mem_ready = 1'b1;
        tick(2);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({mem_rd, mem_wr, mem_addr, acc} !== {1'b1, 1'b0, 4'hE, 8'h00}) begin
                errors++; $display("FAIL wait_operand_%0d got rd=%b wr=%b addr=%h acc=%h want 1 0 e 00",
                                   i, mem_rd, mem_wr, mem_addr, acc);
            end
            tick(1);
        end
        mem_ready = 1'b1;
        tick(1);
        checks++; if ({acc, pc, mem_rd, mem_addr} !== {8'h5A, 4'h1, 1'b1, 4'h1}) begin
            errors++; $display("FAIL wait_lda_8cyc got acc=%h pc=%h rd=%b addr=%h want 5a 1 1 1", acc, pc, mem_rd, mem_addr);
        end
    endtask

    task automatic test_regfile();
        do_reset();
        // LDI 7; MOV 2; LDI 1; ADR 2; MOV 5; MVA 2; MVA 1; HLT
        mem[0] = 8'h57; mem[1] = 8'h92; mem[2] = 8'h51; mem[3] = 8'hB2;
        mem[4] = 8'h95; mem[5] = 8'hA2; mem[6] = 8'hA1; mem[7] = 8'hF0;
        clr = 1'b1;
        tick(8);
        checks++; if ({acc, carry_flag, zero_flag} !== {8'h08, 1'b0, 1'b0}) begin
            errors++; $display("FAIL adr_result got acc=%h c=%b z=%b want 08 0 0", acc, carry_flag, zero_flag);
        end
        tick(2);
        checks++; if ({acc, carry_flag, zero_flag, pc} !== {8'h08, 1'b0, 1'b0, 4'h5}) begin
            errors++; $display("FAIL mov_out_of_range got acc=%h c=%b z=%b pc=%h want 08 0 0 5",
                               acc, carry_flag, zero_flag, pc);
        end
        tick(2);
        checks++; if (acc !== 8'h07) begin errors++; $display("FAIL mva_r2 got %h want 07", acc); end
        tick(2);
        checks++; if ({acc, zero_flag} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL mva_r1_untouched got acc=%h z=%b want 00 1", acc, zero_flag);
        end
        tick(2);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL regfile_halt got %b want 1", halted); end
    endtask

    task automatic test_reset_wrap();
        do_reset();
        mem[0] = 8'h1E; mem[14] = 8'h33;
        clr = 1'b1;
        tick(2);
        mem_ready = 1'b0;
        tick(1);
        checks++; if ({mem_rd, mem_addr, pc} !== {1'b1, 4'hE, 4'h1}) begin
            errors++; $display("FAIL pre_clr_request got rd=%b addr=%h pc=%h want 1 e 1", mem_rd, mem_addr, pc);
        end
        clr = 1'b0;
        #1;
        checks++; if ({mem_rd, mem_wr, pc, acc} !== {1'b0, 1'b0, 4'h0, 8'h00}) begin
            errors++; $display("FAIL async_clr got rd=%b wr=%b pc=%h acc=%h want 0 0 0 00", mem_rd, mem_wr, pc, acc);
        end
        mem[0] = 8'h00;
        @(negedge clk);
        mem_ready = 1'b1;
        clr = 1'b1;
        #1;
        checks++; if ({mem_rd, mem_addr, pc} !== {1'b1, 4'h0, 4'h0}) begin
            errors++; $display("FAIL first_fetch got rd=%b addr=%h pc=%h want 1 0 0", mem_rd, mem_addr, pc);
        end
        mem[14] = 8'h00;
        tick(30);
        checks++; if ({pc, mem_addr, mem_rd} !== {4'hF, 4'hF, 1'b1}) begin
            errors++; $display("FAIL wrap_pre got pc=%h addr=%h rd=%b want f f 1", pc, mem_addr, mem_rd);
        end
        tick(1);
        checks++; if (pc !== 4'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
        tick(2);
        checks++; if ({pc, halted, acc} !== {4'h1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL wrap_continue got pc=%h halted=%b acc=%h want 1 0 00", pc, halted, acc);
        end
    endtask

    initial begin
        clr       = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_basic();
        test_carry_zero();
        test_borrow_store();
        test_wait_states();
        test_regfile();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
